// File: rtl/game_round_ctrl.sv
// Round/target sequencer for a duck-shooting game: start screen, per-duck flight, scoring, round and game end.
// Optional pause on right click in flight is built when the macro GAME_PAUSE_EN is defined.
module game_round_ctrl #(
   parameter int unsigned N_ROUNDS          = 5,
   parameter int unsigned TARGETS_PER_ROUND = 10,
   parameter int unsigned SHOTS_PER_TARGET  = 3,
   parameter int unsigned MIN_HITS          = 6,
   parameter int unsigned TARGET_TIMEOUT    = 260_000_000,
   parameter int unsigned TARGET_SIZE       = 64,
   parameter int unsigned START_XPOS        = 0,
   parameter int unsigned START_YPOS        = 0,
   parameter int unsigned START_W           = 64,
   parameter int unsigned START_H           = 64,
   parameter int unsigned SCORE_W           = 16,
   parameter int unsigned HIT_POINTS        = 100
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               left_mouse,
   input  logic               right_mouse,
   input  logic [11:0]        mouse_xpos,
   input  logic [11:0]        mouse_ypos,
   input  logic [11:0]        target_xpos,
   input  logic [11:0]        target_ypos,
   output logic               start_screen_enable,
   output logic               game_enable,
   output logic               game_end_enable,
   output logic               target_spawn,
   output logic               target_hit,
   output logic               target_escaped,
   output logic               target_active,
   output logic [3:0]         round_num,
   output logic [3:0]         target_cnt,
   output logic [2:0]         shots_left,
   output logic [SCORE_W-1:0] score,
   output logic               game_won,
   output logic               paused
);

   typedef enum logic [2:0] {
      ST_START, ST_SPAWN, ST_FLY, ST_HIT, ST_ESCAPE, ST_ROUND_END, ST_GAME_END
   } state_t;

   localparam logic [31:0]      TO_LAST = 32'(TARGET_TIMEOUT - 1);
   localparam logic [SCORE_W:0] HIT_INC = (SCORE_W + 1)'(HIT_POINTS);

   state_t           state, state_nxt;
   logic             left_prev;
   logic             click;
   logic [31:0]      timeout_cnt;
   logic [3:0]       hits;
   logic             in_box, in_start, timeout_hit, last_target;
   logic [12:0]      mx, my, tx, ty;
   logic [SCORE_W:0] score_sum;

   assign click = left_mouse & ~left_prev;

   // 13-bit compares so a box near the 12-bit edge cannot wrap
   assign mx = {1'b0, mouse_xpos};
   assign my = {1'b0, mouse_ypos};
   assign tx = {1'b0, target_xpos};
   assign ty = {1'b0, target_ypos};

   assign in_box = (mx >= tx) && (mx <= tx + 13'(TARGET_SIZE - 1)) &&
                   (my >= ty) && (my <= ty + 13'(TARGET_SIZE - 1));
   assign in_start = (mx >= 13'(START_XPOS)) && (mx <= 13'(START_XPOS + START_W - 1)) &&
                     (my >= 13'(START_YPOS)) && (my <= 13'(START_YPOS + START_H - 1));

   assign timeout_hit = (timeout_cnt == TO_LAST);
   assign last_target = (target_cnt == 4'(TARGETS_PER_ROUND));
   assign score_sum   = {1'b0, score} + HIT_INC;

`ifdef GAME_PAUSE_EN
   logic right_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         right_prev <= 1'b0;
         paused     <= 1'b0;
      end else begin
         right_prev <= right_mouse;
         if (state == ST_FLY && right_mouse && !right_prev)
            paused <= ~paused;
         else if (state != ST_FLY)
            paused <= 1'b0;
      end
   end
`else
   logic pause_unused;
   assign pause_unused = right_mouse;
   assign paused       = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_START;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt           = state;
      start_screen_enable = 1'b0;
      game_enable         = 1'b0;
      game_end_enable     = 1'b0;
      target_spawn        = 1'b0;
      target_hit          = 1'b0;
      target_escaped      = 1'b0;
      target_active       = 1'b0;
      case (state)
         ST_START: begin
            start_screen_enable = 1'b1;
            if (click && in_start) state_nxt = ST_SPAWN;
         end
         ST_SPAWN: begin
            game_enable  = 1'b1;
            target_spawn = 1'b1;
            state_nxt    = ST_FLY;
         end
         ST_FLY: begin
            game_enable   = 1'b1;
            target_active = 1'b1;
            // A hit takes priority over a timeout landing on the same cycle
            if (!paused) begin
               if (click && in_box)
                  state_nxt = ST_HIT;
               else if ((click && shots_left == 3'd1) || timeout_hit)
                  state_nxt = ST_ESCAPE;
            end
         end
         ST_HIT: begin
            game_enable = 1'b1;
            target_hit  = 1'b1;
            state_nxt   = last_target ? ST_ROUND_END : ST_SPAWN;
         end
         ST_ESCAPE: begin
            game_enable    = 1'b1;
            target_escaped = 1'b1;
            state_nxt      = last_target ? ST_ROUND_END : ST_SPAWN;
         end
         ST_ROUND_END: begin
            game_enable = 1'b1;
            if (hits < 4'(MIN_HITS) || round_num == 4'(N_ROUNDS))
               state_nxt = ST_GAME_END;
            else
               state_nxt = ST_SPAWN;
         end
         ST_GAME_END: begin
            game_end_enable = 1'b1;
            if (click) state_nxt = ST_START;
         end
         default: state_nxt = ST_START;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         left_prev   <= 1'b0;
         timeout_cnt <= '0;
         hits        <= '0;
         round_num   <= '0;
         target_cnt  <= '0;
         shots_left  <= '0;
         score       <= '0;
         game_won    <= 1'b0;
      end else begin
         left_prev <= left_mouse;
         case (state)
            ST_START: begin
               if (click && in_start) begin
                  score      <= '0;
                  round_num  <= 4'd1;
                  target_cnt <= '0;
                  hits       <= '0;
                  game_won   <= 1'b0;
               end
            end
            ST_SPAWN: begin
               shots_left  <= 3'(SHOTS_PER_TARGET);
               timeout_cnt <= '0;
               target_cnt  <= target_cnt + 4'd1;
            end
            ST_FLY: begin
               if (!paused) begin
                  timeout_cnt <= timeout_cnt + 32'd1;
                  if (click && !in_box) shots_left <= shots_left - 3'd1;
               end
            end
            ST_HIT: begin
               score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
               hits  <= hits + 4'd1;
            end
            ST_ROUND_END: begin
               if (hits >= 4'(MIN_HITS)) begin
                  if (round_num == 4'(N_ROUNDS)) begin
                     game_won <= 1'b1;
                  end else begin
                     round_num  <= round_num + 4'd1;
                     target_cnt <= '0;
                     hits       <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with a short duck timeout; pause checks follow GAME_PAUSE_EN.
module tb_game_round_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        left_mouse, right_mouse;
   logic [11:0] mouse_xpos, mouse_ypos, target_xpos, target_ypos;
   logic        start_screen_enable, game_enable, game_end_enable;
   logic        target_spawn, target_hit, target_escaped, target_active;
   logic [3:0]  round_num, target_cnt;
   logic [2:0]  shots_left;
   logic [15:0] score;
   logic        game_won, paused;

   int checks    = 0;
   int failures  = 0;
   int spawn_cnt = 0;
   int hit_cnt   = 0;
   int esc_cnt   = 0;

   game_round_ctrl #(
      .N_ROUNDS(5), .TARGETS_PER_ROUND(10), .SHOTS_PER_TARGET(3), .MIN_HITS(6),
      .TARGET_TIMEOUT(20), .TARGET_SIZE(64),
      .START_XPOS(0), .START_YPOS(0), .START_W(64), .START_H(64),
      .SCORE_W(16), .HIT_POINTS(100)
   ) dut (
      .clk(clk), .rst(rst), .left_mouse(left_mouse), .right_mouse(right_mouse),
      .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
      .target_xpos(target_xpos), .target_ypos(target_ypos),
      .start_screen_enable(start_screen_enable), .game_enable(game_enable),
      .game_end_enable(game_end_enable), .target_spawn(target_spawn),
      .target_hit(target_hit), .target_escaped(target_escaped),
      .target_active(target_active), .round_num(round_num), .target_cnt(target_cnt),
      .shots_left(shots_left), .score(score), .game_won(game_won), .paused(paused)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (target_spawn)   spawn_cnt++;
      if (target_hit)     hit_cnt++;
      if (target_escaped) esc_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic click_at(input int x, input int y);
      @(negedge clk);
      mouse_xpos = 12'(x);
      mouse_ypos = 12'(y);
      left_mouse = 1'b1;
      @(negedge clk);
      left_mouse = 1'b0;
   endtask

   task automatic wait_fly();
      logic seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (target_active) seen = 1'b1;
      end
      check("wait_fly", 32'(seen), 32'd1);
   endtask

   task automatic wait_end();
      logic seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (game_end_enable) seen = 1'b1;
      end
      check("wait_end", 32'(seen), 32'd1);
   endtask

   task automatic hit_duck();
      wait_fly();
      click_at(100, 100);
   endtask

   task automatic esc_duck();
      wait_fly();
      repeat (3) click_at(0, 0);
   endtask

   initial begin
      int n;
      int esc0;
      rst = 1'b1;
      left_mouse = 1'b0; right_mouse = 1'b0;
      mouse_xpos = '0; mouse_ypos = '0;
      target_xpos = 12'd100; target_ypos = 12'd100;
      repeat (3) @(negedge clk);
      check("rst_start_scr", 32'(start_screen_enable), 32'd1);
      check("rst_game_en",   32'(game_enable), 32'd0);
      check("rst_end_en",    32'(game_end_enable), 32'd0);
      check("rst_active",    32'(target_active), 32'd0);
      check("rst_score",     32'(score), 32'd0);
      check("rst_round",     32'(round_num), 32'd0);
      check("rst_tcnt",      32'(target_cnt), 32'd0);
      check("rst_shots",     32'(shots_left), 32'd0);
      check("rst_won",       32'(game_won), 32'd0);
      check("rst_paused",    32'(paused), 32'd0);
      rst = 1'b0;

      // just right of the start rectangle: must stay on start screen
      click_at(64, 0);
      repeat (2) @(negedge clk);
      check("start_edge_miss", 32'(start_screen_enable), 32'd1);
      check("start_no_spawn",  32'(spawn_cnt), 32'd0);

      click_at(0, 0);
      wait_fly();
      check("g1_spawn_cnt", 32'(spawn_cnt), 32'd1);
      check("g1_round",     32'(round_num), 32'd1);
      check("g1_tcnt",      32'(target_cnt), 32'd1);
      check("g1_shots",     32'(shots_left), 32'd3);
      check("g1_game_en",   32'(game_enable), 32'd1);

      // duck 1: two boundary misses then a corner hit
      click_at(164, 100);
      check("d1_miss_x_shots", 32'(shots_left), 32'd2);
      check("d1_miss_x_act",   32'(target_active), 32'd1);
      click_at(100, 99);
      check("d1_miss_y_shots", 32'(shots_left), 32'd1);
      click_at(163, 163);
      check("d1_hit_pulse", 32'(target_hit), 32'd1);
      wait_fly();
      check("d1_hit_cnt", 32'(hit_cnt), 32'd1);
      check("d1_score",   32'(score), 32'd100);
      check("d2_tcnt",    32'(target_cnt), 32'd2);
      check("d2_shots",   32'(shots_left), 32'd3);

      // duck 2: three outside clicks
      click_at(0, 0);
      click_at(0, 0);
      check("d2_shots_1", 32'(shots_left), 32'd1);
      click_at(0, 0);
      check("d2_esc_pulse", 32'(target_escaped), 32'd1);
      wait_fly();
      check("d2_esc_cnt", 32'(esc_cnt), 32'd1);
      check("d2_score",   32'(score), 32'd100);

      // duck 3: timeout after exactly 20 flying cycles
      repeat (19) @(negedge clk);
      check("d3_still_active", 32'(target_active), 32'd1);
      @(negedge clk);
      check("d3_timeout_esc", 32'(target_escaped), 32'd1);

      // duck 4: hit click on the timeout cycle
      wait_fly();
      repeat (18) @(negedge clk);
      click_at(120, 120);
      check("d4_hit_wins", 32'(target_hit), 32'd1);
      check("d4_no_esc",   32'(target_escaped), 32'd0);

      wait_fly();
      check("d5_hit_cnt", 32'(hit_cnt), 32'd2);
      check("d5_esc_cnt", 32'(esc_cnt), 32'd2);
      check("d5_score",   32'(score), 32'd200);
      check("d5_tcnt",    32'(target_cnt), 32'd5);
`ifdef GAME_PAUSE_EN
      @(negedge clk); right_mouse = 1'b1;
      @(negedge clk); right_mouse = 1'b0;
      check("pause_on", 32'(paused), 32'd1);
      repeat (40) @(negedge clk);
      check("pause_active", 32'(target_active), 32'd1);
      check("pause_no_esc", 32'(esc_cnt), 32'd2);
      click_at(100, 100);
      repeat (2) @(negedge clk);
      check("pause_click_ignored", 32'(hit_cnt), 32'd2);
      check("pause_active2", 32'(target_active), 32'd1);
      @(negedge clk); right_mouse = 1'b1;
      @(negedge clk); right_mouse = 1'b0;
      n = 1;
      check("pause_off", 32'(paused), 32'd0);
      while (!target_escaped && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("pause_resume_esc_at", 32'(n), 32'd19);
`else
      @(negedge clk); right_mouse = 1'b1;
      @(negedge clk); right_mouse = 1'b0;
      check("nopause_paused", 32'(paused), 32'd0);
      repeat (17) @(negedge clk);
      check("nopause_active", 32'(target_active), 32'd1);
      @(negedge clk);
      check("nopause_esc", 32'(target_escaped), 32'd1);
`endif

      repeat (3) hit_duck();
      repeat (2) esc_duck();
      wait_end();
      check("g1_end_en",  32'(game_end_enable), 32'd1);
      check("g1_won",     32'(game_won), 32'd0);
      check("g1_score",   32'(score), 32'd500);
      check("g1_round_f", 32'(round_num), 32'd1);
      check("g1_tcnt_f",  32'(target_cnt), 32'd10);
      check("g1_spawns",  32'(spawn_cnt), 32'd10);
      check("g1_hits",    32'(hit_cnt), 32'd5);
      check("g1_escs",    32'(esc_cnt), 32'd5);

      click_at(500, 500);
      @(negedge clk);
      check("end_to_start", 32'(start_screen_enable), 32'd1);
      check("score_holds",  32'(score), 32'd500);

      click_at(10, 10);
      wait_fly();
      check("g2_score_clr", 32'(score), 32'd0);
      check("g2_round",     32'(round_num), 32'd1);
      for (int d = 0; d < 50; d++) begin
         if (d > 0) wait_fly();
         if (d == 10) begin
            check("g2_round2", 32'(round_num), 32'd2);
            check("g2_tcnt_r2", 32'(target_cnt), 32'd1);
         end
         click_at(100, 100);
      end
      wait_end();
      check("g2_won",   32'(game_won), 32'd1);
      check("g2_score", 32'(score), 32'd5000);
      check("g2_round", 32'(round_num), 32'd5);

      // reset in flight: async abort, no escape pulse
      click_at(0, 0);
      click_at(0, 0);
      wait_fly();
      esc0 = esc_cnt;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstfly_active", 32'(target_active), 32'd0);
      check("rstfly_start",  32'(start_screen_enable), 32'd1);
      check("rstfly_score",  32'(score), 32'd0);
      check("rstfly_round",  32'(round_num), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check("rstfly_no_esc", 32'(esc_cnt), 32'(esc0));
      check("rstfly_idle",   32'(start_screen_enable), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
